// File: rtl/mmu_operand_feeder.sv
// Operand feeder for the 2x2 systolic matrix multiplier: stores A/B and streams them diagonally skewed.
// Optional macro MMU_FEEDER_TRANSPOSE_B_EN: B writes land transposed (host loads B column-major).
module mmu_operand_feeder #(
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [1:0]             wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [1:0][DATA_W-1:0] a_out,
  output logic [1:0][DATA_W-1:0] b_out,
  output logic                   valid_out
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [DATA_W-1:0]       mat_a [4];
  logic [DATA_W-1:0]       mat_b [4];
  logic [DATA_W-1:0]       mat_a_nxt [4];
  logic [DATA_W-1:0]       mat_b_nxt [4];
  logic [1:0][DATA_W-1:0]  a_nxt, b_nxt;
  logic [1:0]              b_idx;

`ifdef MMU_FEEDER_TRANSPOSE_B_EN
  assign b_idx = {wr_addr[0], wr_addr[1]};
`else
  assign b_idx = wr_addr;
`endif

  assign busy      = (state == STREAM) || (state == FLUSH);
  assign done      = (state == DONE);
  assign valid_out = (state == STREAM);

  // Storage is indexed row*2+col; a write in the start cycle must feed step 0, hence the _nxt view.
  always_comb begin
    mat_a_nxt = mat_a;
    mat_b_nxt = mat_b;
    if (wr_en && !busy) begin
      if (wr_sel) mat_b_nxt[b_idx]   = wr_data;
      else        mat_a_nxt[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mat_a[i] <= '0;
        mat_b[i] <= '0;
      end
    end else begin
      mat_a <= mat_a_nxt;
      mat_b <= mat_b_nxt;
    end
  end

  // Operand lanes are computed one step ahead so a_out/b_out come straight from flops.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = '0;
    b_nxt     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          cnt_nxt   = 4'd0;
          a_nxt[0]  = mat_a_nxt[0];
          b_nxt[0]  = mat_b_nxt[0];
        end
      end
      STREAM: begin
        if (cnt == 4'd2) begin
          state_nxt = FLUSH;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == 4'd0) begin
            a_nxt[0] = mat_a[1];
            a_nxt[1] = mat_a[2];
            b_nxt[0] = mat_b[2];
            b_nxt[1] = mat_b[1];
          end else begin
            a_nxt[1] = mat_a[3];
            b_nxt[1] = mat_b[3];
          end
        end
      end
      FLUSH: begin
        if (cnt == 4'(DRAIN_CYCLES - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      a_out <= a_nxt;
      b_out <= b_nxt;
    end
  end

endmodule

// File: tb/tb_mmu_operand_feeder.sv
// Scoreboard bench for mmu_operand_feeder: a matrix-level model predicts skewed beats, a monitor checks them.
module tb_mmu_operand_feeder;
  localparam int DW    = 8;
  localparam int DRAIN = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr_en, wr_sel, start;
  logic [1:0]          wr_addr;
  logic [DW-1:0]       wr_data;
  logic                busy, done, valid_out;
  logic [1:0][DW-1:0]  a_out, b_out;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0]   ref_a [2][2];
  logic [DW-1:0]   ref_b [2][2];
  logic [4*DW-1:0] exp_q [$];

  mmu_operand_feeder #(.DATA_W(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Lane i of the array sees its operands i cycles late: A row r at step t carries column t-r.
  function automatic logic [4*DW-1:0] beat(input int t);
    logic [DW-1:0] av [2];
    logic [DW-1:0] bv [2];
    for (int r = 0; r < 2; r++) begin
      int c;
      c = t - r;
      av[r] = (c >= 0 && c < 2) ? ref_a[r][c] : '0;
    end
    for (int c = 0; c < 2; c++) begin
      int r;
      r = t - c;
      bv[c] = (r >= 0 && r < 2) ? ref_b[r][c] : '0;
    end
    return {av[0], av[1], bv[0], bv[1]};
  endfunction

  function automatic void modelWrite(input bit sel, input logic [1:0] addr, input logic [DW-1:0] d);
    if (!sel) ref_a[addr[1]][addr[0]] = d;
`ifdef MMU_FEEDER_TRANSPOSE_B_EN
    else      ref_b[addr[0]][addr[1]] = d;
`else
    else      ref_b[addr[1]][addr[0]] = d;
`endif
  endfunction

  function automatic void modelClear();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        ref_a[r][c] = '0;
        ref_b[r][c] = '0;
      end
  endfunction

  task automatic writeElem(input bit sel, input logic [1:0] addr, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = d;
    modelWrite(sel, addr, d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issues one run; in_done means we are in the DONE cycle and start must survive into the next IDLE.
  task automatic applyStimulus(input bit in_done, input bit same_write, input logic [DW-1:0] wval,
                               input bit mid_write);
    int k;
    start = 1'b1;
    if (same_write) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = wval;
      modelWrite(1'b0, 2'd0, wval);
    end
    for (int t = 0; t < 3; t++) exp_q.push_back(beat(t));
    if (in_done) begin
      @(negedge clk);
      wr_en = 1'b0;
      checkOutput("done_one_cycle", {63'd0, done}, 64'd0);
      checkOutput("start_in_done_ignored", {63'd0, valid_out}, 64'd0);
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    k = 1;
    while (k < 40 && done !== 1'b1) begin
      checkOutput("busy_during_run", {63'd0, busy}, 64'd1);
      if (mid_write && k == 2) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'd99; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; wr_en = 1'b0;
    checkOutput("run_length", 64'(k), 64'(3 + DRAIN + 1));
    checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
  endtask

  // Monitor: every valid beat must match the head of the scoreboard; idle lanes must be zero.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", {32'd0, a_out, b_out}, 64'd0);
        end else begin
          checkOutput("stream_beat", {32'd0, a_out[0], a_out[1], b_out[0], b_out[1]},
                      {32'd0, exp_q.pop_front()});
        end
      end else begin
        checkOutput("zero_pad", {32'd0, a_out, b_out}, 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = '0; start = 1'b0;
    modelClear();
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_valid", {63'd0, valid_out}, 64'd0);
    checkOutput("reset_lanes", {32'd0, a_out, b_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) writeElem(1'b0, 2'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) writeElem(1'b1, 2'(i), 8'(i + 5));
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("done_pulse_width", {63'd0, done}, 64'd0);

    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 8'd9, 1'b0);
    @(negedge clk);

    start = 1'b1;
    for (int t = 0; t < 3; t++) exp_q.push_back(beat(t));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("flush_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrun_reset_valid", {63'd0, valid_out}, 64'd0);
    checkOutput("midrun_reset_done", {63'd0, done}, 64'd0);
    checkOutput("midrun_reset_lanes", {32'd0, a_out, b_out}, 64'd0);
    modelClear();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checkOutput("no_done_after_reset", 64'(seen), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 4; i++) writeElem(1'b0, 2'(i), 8'($urandom));
    for (int i = 0; i < 4; i++) writeElem(1'b1, 2'(i), 8'($urandom));
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);

    writeElem(1'b1, 2'd1, 8'd6);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      writeElem(1'($urandom), 2'($urandom), 8'($urandom));
      writeElem(1'($urandom), 2'($urandom), 8'($urandom));
      applyStimulus(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmu_operand_feeder.md
Name: mmu_operand_feeder

Overview:
- Upstream feeder for the 2x2 systolic matrix multiplier.
- Holds one 2x2 A matrix and one 2x2 B matrix, loaded by a simple write port.
- On start, streams the operands diagonally skewed onto the array's row/column inputs with a valid strobe, zero-pads while the array drains, then signals done.
- Sits between the host/control register block and the matrix multiplier unit.

Parameters:
- DATA_W, 8, operand width; must match array input width.
- DRAIN_CYCLES, 4, zero-padded cycles after the last operand step before done; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- wr_en  input  1  write strobe for matrix storage
- wr_sel  input  1  0 = write A, 1 = write B
- wr_addr  input  2  element index = row*2 + col
- wr_data  input  DATA_W  element value
- start  input  1  begin a stream; sampled only in IDLE
- busy  output  1  high in STREAM and FLUSH
- done  output  1  one-cycle pulse at end of run
- a_out[1:0]  output  2 x DATA_W  row-skewed A operands, one lane per array row
- b_out[1:0]  output  2 x DATA_W  column-skewed B operands, one lane per array column
- valid_out  output  1  high while a_out/b_out carry stream steps

Behaviour:
Reset (asynchronous, any time including mid-run):
- All matrix registers = 0.
- State = IDLE.
- a_out = b_out = 0; valid_out = busy = done = 0.

Storage:
- 8 registers: A[r][c] and B[r][c].
- A write applies at the clock edge when wr_en=1.
- Writes are ignored while busy=1. No error flag.

FSM states: IDLE, STREAM, FLUSH, DONE.
- IDLE: outputs zero, valid_out=0. start=1 at edge E0 -> STREAM, step 0.
  - If wr_en and start are both high at E0, the write lands first; the stream uses the new value.
- STREAM: 3 steps (2N-1), step counter 0..2. All outputs are registered.
  - After E0: step0 values, valid_out=1, busy=1.
  - After E0+1: step1. After E0+2: step2.
- FLUSH: after E0+3, a_out=b_out=0, valid_out=0, busy=1. Lasts DRAIN_CYCLES edges.
- DONE: one cycle with done=1, busy=0, then IDLE.
  - start during DONE is ignored.
  - start in the following IDLE cycle begins a new run.
- start while busy: ignored, not queued.

Skew schedule (lane i is delayed i cycles):
- step0: a_out[0]=A[0][0], a_out[1]=0, b_out[0]=B[0][0], b_out[1]=0
- step1: a_out[0]=A[0][1], a_out[1]=A[1][0], b_out[0]=B[1][0], b_out[1]=B[0][1]
- step2: a_out[0]=0, a_out[1]=A[1][1], b_out[0]=0, b_out[1]=B[1][1]

General rules:
- Values pass through unmodified; no arithmetic, no width change.
- Total run: start edge to done pulse = 3 + DRAIN_CYCLES + 1 cycles.
- Matrix registers are retained after a run; a repeated start replays the identical stream.

Optional Feature:
- Macro: MMU_FEEDER_TRANSPOSE_B_EN.
- Defined: writes with wr_sel=1 store wr_data into B[col][row], where row = wr_addr[1] and col = wr_addr[0]. The host can therefore load B column-major. A writes are unaffected.
- Undefined: B[row][col], identical to A addressing.
- The stream schedule is the same in both builds.

Test Plan:
- Load A=[[1,2],[3,4]], B=[[5,6],[7,8]]; pulse start. Over the 3 valid cycles expect:
  - a_out[0]=1,2,0; a_out[1]=0,3,4
  - b_out[0]=5,7,0; b_out[1]=0,6,8
  - valid_out=1,1,1; then 4 zero cycles with busy=1; then done=1 for one cycle with busy=0.
- During a run, write A[0][0]=99 and pulse start at step1 -> stream unchanged, no second run. A later start shows a_out[0] step0 = 1 (write was ignored).
- In IDLE, wr_en (A[0][0]=9) and start in the same cycle -> step0 a_out[0]=9.
- Assert rst during FLUSH -> next cycle: busy=0, valid_out=0, outputs 0, no done pulse. A new start after loading streams correctly.
- With MMU_FEEDER_TRANSPOSE_B_EN: write wr_sel=1, wr_addr=1, value 6 -> appears at step1 on b_out[0] (as B[1][0]), not on b_out[1]. Without the macro -> appears at step1 on b_out[1].
- Back-to-back runs: start in the cycle after done -> second stream identical to the first. Total 8 cycles per run with DRAIN_CYCLES=4.
